axil_regtest_master: RTL
========================

# axil_regtest_master

Synthesisable, parametrised AXI4-Lite master that performs a self-checking register write/read-back sweep over a slave's register window. It generates N write/read pairs at a configurable base and stride, compares the read data and checks every response code, and reports pass/fail, an error count and the first failing address. It sits beside driver IPs in block designs as a built-in register self-test that replaces bench-only BFM sequences and also runs on hardware.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (32 or 64)
- C_BASE_ADDR, 32'h0, first register address
- C_NUM_REGS, 4, registers swept (1..256)
- C_ADDR_STRIDE, 4, address increment per register
- C_SEED, 32'h0101FFFF, pattern seed (zero-extended to data width)
- C_TIMEOUT, 1024, max cycles waiting in any handshake state
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset; one clock, synchronous, active-low
- start  in  1  pulse; begins a sweep when idle
- mode  in  1  0 = interleaved (write i, read i), 1 = burst (write all, then read all)
- pattern  in  1  0 = incrementing (C_SEED + i), 1 = 32-bit Galois LFSR, taps 0x80200003
- busy, done, pass, timeout  out  1 each  status
- err_count  out  8  mismatches plus non-OKAY responses, saturating at 255
- first_err_addr  out  C_M_AXI_ADDR_WIDTH  address of first error
- M_AXI_AWADDR/AWPROT/AWVALID, AWREADY; M_AXI_WDATA/WSTRB/WVALID, WREADY; M_AXI_BRESP/BVALID, BREADY; M_AXI_ARADDR/ARPROT/ARVALID, ARREADY; M_AXI_RDATA/RRESP/RVALID, RREADY: standard AXI4-Lite master; AWPROT = ARPROT = 3'b000, WSTRB all ones

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, NEXT, FINISH.
- IDLE: start=1 clears done/pass/timeout/err_count/first_err_addr, loads index=0 and pattern generator from C_SEED, enters WR_REQ. start while busy is ignored.
- WR_REQ: AWVALID and WVALID asserted together; each drops independently after its own handshake; leave when both done -> WR_RESP.
- WR_RESP: BREADY=1; on BVALID, BRESP != 2'b00 is an error -> interleaved: RD_REQ; burst: NEXT.
- RD_REQ: ARVALID until ARREADY -> RD_RESP. RD_RESP: RREADY=1; on RVALID, error if RRESP != OKAY or RDATA != expected -> NEXT.
- NEXT: index+1; address = C_BASE_ADDR + index*C_ADDR_STRIDE (mod 2^ADDR_WIDTH, wraps silently). Burst mode: after last write, reload index=0 and generator from C_SEED, go to RD_REQ; after last read -> FINISH. Interleaved: after last read -> FINISH.
- Expected data for index i regenerated identically in read phase; LFSR advances once per register, never per cycle. Incrementing: C_SEED + i, modulo data width.
- Each error: err_count increments (saturates 255); first_err_addr latched only on the first error of the sweep.
- Timeout: a counter resets on entry to each handshake state; reaching C_TIMEOUT sets timeout, counts one error, drops all VALID/READY, -> FINISH. No further transactions issued.
- FINISH: done=1, pass = (err_count==0 && !timeout), busy=0, -> IDLE. done/pass held until next start.

## Timing
- Reset values: all VALID/READY 0, busy/done/pass/timeout 0, err_count 0, first_err_addr 0, addresses/data 0.
- Reset mid-sweep: outputs return to reset values on the sampling edge; no transaction completion afterwards; busy=0.
- AWVALID/WVALID first high the cycle after start is sampled. busy high from that cycle through last response.
- VALIDs stay asserted with stable ADDR/DATA until handshake (AXI rule); VALID never depends on READY.
- Zero-wait slave: write = 2 cycles (req, resp), read = 2 cycles, NEXT 1 cycle; interleaved sweep = 5*C_NUM_REGS + 1 cycles start-to-done.
- BVALID/RVALID sampled only in their respective response states.

## Test plan
- Zero-wait RAM slave, defaults, mode 0, pattern 0 -> writes 0x0101FFFF, 0x01020000, 0x01020001, 0x01020002 to 0x0, 0x4, 0x8, 0xC; done after 21 cycles, pass=1, err_count=0.
- Mode 1, pattern 1, random AWREADY/WREADY/ARREADY stalls, independent AW vs W order -> all four writes precede first read; read data matches LFSR sequence; pass=1.
- Slave corrupts bit 0 of register 2 -> err_count=1, first_err_addr=0x8, pass=0.
- Slave returns SLVERR on write 1 and read 3 -> err_count=2, first_err_addr=0x4.
- Slave never asserts BVALID -> after 1024 cycles timeout=1, err_count=1, all VALIDs low, done=1, pass=0.
- ARESETN low for one cycle during RD_RESP, then start -> all outputs at reset values next cycle; restarted sweep passes cleanly.

Source files
------------

// File: rtl/axil_regtest_master.sv
// AXI4-Lite register self-test master: writes a pattern across a register window,
// reads it back and reports pass/fail, error count and the first failing address.
module axil_regtest_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int                            C_NUM_REGS         = 4,
  parameter int                            C_ADDR_STRIDE      = 4,
  parameter logic [31:0]                   C_SEED             = 32'h0101FFFF,
  parameter int                            C_TIMEOUT          = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            mode,
  input  logic                            pattern,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [7:0]                      err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   first_err_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int                DATA_W    = C_M_AXI_DATA_WIDTH;
  localparam int                ADDR_W    = C_M_AXI_ADDR_WIDTH;
  localparam int                TW        = $clog2(C_TIMEOUT + 1);
  localparam logic [7:0]        LAST_IDX  = 8'(C_NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(C_ADDR_STRIDE);
  localparam logic [DATA_W-1:0] SEED_EXT  = DATA_W'(C_SEED);
  localparam logic [31:0]       LFSR_TAPS = 32'h80200003;
  localparam logic [TW-1:0]     TMO_LAST  = TW'(C_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_NEXT, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [TW-1:0]       tmo_cnt_q;
  logic                aw_done_q, w_done_q;
  logic                rd_phase_q, mode_q, pattern_q;
  logic                aw_hs, w_hs, wr_req_done, in_hs, tmo_hit, last_idx;
  logic                err_ev, tmo_ev;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One generator step per register: Galois LFSR in the low 32 bits, or +1.
  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] cur,
                                                 input logic use_lfsr);
    logic [31:0] s;
    s = cur[31:0];
    if (use_lfsr)
      return DATA_W'(s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1));
    return cur + DATA_W'(1);
  endfunction

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARVALID = (state_q == S_RD_REQ);
  assign M_AXI_RREADY  = (state_q == S_RD_RESP);

  assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
  assign wr_req_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign in_hs       = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                       (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
  assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
  assign last_idx    = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    err_ev  = 1'b0;
    tmo_ev  = 1'b0;
    case (state_q)
      S_IDLE:
        if (start) state_d = S_WR_REQ;
      S_WR_REQ:
        if (wr_req_done) state_d = S_WR_RESP;
        else if (tmo_hit) begin
          tmo_ev  = 1'b1;
          state_d = S_FINISH;
        end
      S_WR_RESP:
        if (M_AXI_BVALID) begin
          err_ev  = (M_AXI_BRESP != 2'b00);
          state_d = mode_q ? S_NEXT : S_RD_REQ;
        end else if (tmo_hit) begin
          tmo_ev  = 1'b1;
          state_d = S_FINISH;
        end
      S_RD_REQ:
        if (M_AXI_ARREADY) state_d = S_RD_RESP;
        else if (tmo_hit) begin
          tmo_ev  = 1'b1;
          state_d = S_FINISH;
        end
      S_RD_RESP:
        if (M_AXI_RVALID) begin
          err_ev  = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_q);
          state_d = S_NEXT;
        end else if (tmo_hit) begin
          tmo_ev  = 1'b1;
          state_d = S_FINISH;
        end
      S_NEXT:
        if (mode_q && !rd_phase_q) state_d = last_idx ? S_RD_REQ : S_WR_REQ;
        else if (last_idx)         state_d = S_FINISH;
        else                       state_d = mode_q ? S_RD_REQ : S_WR_REQ;
      S_FINISH:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      tmo_cnt_q      <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      rd_phase_q     <= 1'b0;
      mode_q         <= 1'b0;
      pattern_q      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state_q <= state_d;

      // The watchdog restarts on every state change, so each handshake gets its own budget.
      if (state_d != state_q) tmo_cnt_q <= '0;
      else if (in_hs)         tmo_cnt_q <= tmo_cnt_q + TW'(1);

      if (state_q == S_WR_REQ && state_d == S_WR_REQ) begin
        aw_done_q <= aw_done_q || aw_hs;
        w_done_q  <= w_done_q || w_hs;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end

      if (err_ev || tmo_ev) begin
        err_count <= sat_inc(err_count);
        if (err_count == 8'd0) first_err_addr <= addr_q;
      end
      if (tmo_ev) timeout <= 1'b1;

      case (state_q)
        S_IDLE:
          if (start) begin
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            idx_q          <= '0;
            addr_q         <= C_BASE_ADDR;
            data_q         <= SEED_EXT;
            rd_phase_q     <= 1'b0;
            mode_q         <= mode;
            pattern_q      <= pattern;
          end
        S_NEXT:
          if (mode_q && !rd_phase_q && last_idx) begin
            // Burst read phase replays the generator from the seed.
            idx_q      <= '0;
            addr_q     <= C_BASE_ADDR;
            data_q     <= SEED_EXT;
            rd_phase_q <= 1'b1;
          end else if (!last_idx) begin
            idx_q  <= idx_q + 8'd1;
            addr_q <= addr_q + STRIDE;
            data_q <= pat_next(data_q, pattern_q);
          end
        S_FINISH: begin
          done <= 1'b1;
          pass <= (err_count == 8'd0) && !timeout;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
